// File: rtl/match_grant_scheduler.sv
// match_grant_scheduler
//
// Batch scheduler in front of a priority encoder. One request vector is
// accepted per batch; the scheduler then issues one grant per set bit, lowest
// index first. Grant indices are 1-based (bit k -> index k+1), and 127 means
// "no grant". Each bit is cleared when its grant is accepted. A one-cycle
// done pulse marks normal completion of the batch.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds its payload stable while valid && !ready.
// abort takes priority over both handshakes in the same cycle.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active-high (overrides everything)
//   req_valid    request vector offered
//   req_ready    scheduler idle and can accept a vector
//   req_vec      request bits, WIDTH-1 wide; bit k maps to index k+1
//   abort        drop the current batch (no done pulse)
//   grant_valid  grant_idx holds a pending grant
//   grant_ready  consumer accepts the grant
//   grant_idx    1-based index of the lowest pending bit, 127 when idle
//   grant_last   the presented grant is the final one of the batch
//   grant_count  grants accepted in the current or most recent batch
//   busy         batch in progress (ISSUE or FINISH)
//   done         one-cycle pulse when a batch completes normally
//
// The grant index is 7 bits wide, so WIDTH-1 must not exceed 126.
module match_grant_scheduler #(
  parameter int WIDTH = 87
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-2:0] req_vec,
  input  logic             abort,
  output logic             grant_valid,
  input  logic             grant_ready,
  output logic [6:0]       grant_idx,
  output logic             grant_last,
  output logic [6:0]       grant_count,
  output logic             busy,
  output logic             done
);

  localparam int N = WIDTH - 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  logic [1:0]   state;
  logic [N-1:0] pending;

  // Lowest set bit k encodes as k+1; an empty vector encodes as 127.
  function automatic logic [6:0] prio_enc(input logic [N-1:0] v);
    logic [6:0] r;
    r = 7'd127;
    for (int k = N - 1; k >= 0; k--) begin
      if (v[k]) r = 7'(k + 1);
    end
    return r;
  endfunction

  logic         grant_fire;
  logic         accept;
  logic [N-1:0] clr_mask;
  logic [N-1:0] pend_after;
  logic [N-1:0] load_vec;
  logic [6:0]   load_idx;
  logic         load_last;

  assign accept     = req_valid && req_ready;
  // abort suppresses a coincident grant handshake.
  assign grant_fire = grant_valid && grant_ready && !abort;
  assign clr_mask   = {{(N-1){1'b0}}, 1'b1} << (grant_idx - 7'd1);
  assign pend_after = pending & ~clr_mask;

  // The grant registers are loaded on the same edge that pending is written,
  // so they are computed from the value pending is about to take.
  assign load_vec  = (state == ST_IDLE) ? req_vec : pend_after;
  assign load_idx  = prio_enc(load_vec);
  assign load_last = ($countones(load_vec) == 1);

  assign req_ready = (state == ST_IDLE) && !abort;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_FINISH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      pending     <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= 7'd127;
      grant_last  <= 1'b0;
      grant_count <= 7'd0;
    end else if (abort) begin
      // grant_count deliberately keeps its value at abort time.
      state       <= ST_IDLE;
      pending     <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= 7'd127;
      grant_last  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            pending     <= req_vec;
            grant_count <= 7'd0;
            if (req_vec != '0) begin
              state       <= ST_ISSUE;
              grant_valid <= 1'b1;
              grant_idx   <= load_idx;
              grant_last  <= load_last;
            end else begin
              state <= ST_FINISH;
            end
          end
        end
        ST_ISSUE: begin
          if (grant_fire) begin
            pending     <= pend_after;
            grant_count <= grant_count + 7'd1;
            if (pend_after != '0) begin
              grant_idx  <= load_idx;
              grant_last <= load_last;
            end else begin
              state       <= ST_FINISH;
              grant_valid <= 1'b0;
              grant_idx   <= 7'd127;
              grant_last  <= 1'b0;
            end
          end
        end
        ST_FINISH: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_match_grant_scheduler.sv
// Testbench for match_grant_scheduler. Expected grants ({last, idx}) are
// pushed to exp_q when a request is driven and popped when the scheduler
// presents a grant that will be accepted.
module tb_match_grant_scheduler;

  localparam int WIDTH = 87;
  localparam int N     = WIDTH - 1;

  logic         clk;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [N-1:0] req_vec;
  logic         abort;
  logic         grant_valid;
  logic         grant_ready;
  logic [6:0]   grant_idx;
  logic         grant_last;
  logic [6:0]   grant_count;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  match_grant_scheduler #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_vec     (req_vec),
    .abort       (abort),
    .grant_valid (grant_valid),
    .grant_ready (grant_ready),
    .grant_idx   (grant_idx),
    .grant_last  (grant_last),
    .grant_count (grant_count),
    .busy        (busy),
    .done        (done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver: offers vec for one accept edge and pushes up to max_push expected
  // grants. req_vec is scrambled afterwards; the scheduler must ignore it.
  task automatic drive_req(input logic [N-1:0] vec, input int max_push);
    int n;
    int seen;
    n = $countones(vec);
    seen = 0;
    for (int k = 0; k < N; k++) begin
      if (vec[k]) begin
        seen++;
        if (seen <= max_push) exp_q.push_back({(seen == n), 7'(k + 1)});
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_vec   = vec;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_vec   = ~vec;
  endtask

  task automatic test_reset;
    int dcount;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || grant_valid !== 1'b0 || grant_idx !== 7'd127 ||
        grant_count !== 7'd0 || busy !== 1'b0 || grant_last !== 1'b0)
      begin
        errors++;
        $display("FAIL reset_vals: ready=%b gv=%b idx=%0d cnt=%0d busy=%b last=%b, need 1 0 127 0 0 0",
                 req_ready, grant_valid, grant_idx, grant_count, busy, grant_last);
      end
    dcount = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    checks++;
    if (dcount != 0) begin
      errors++;
      $display("FAIL reset_idle_done: done pulses=%0d, need 0", dcount);
    end
  endtask

  task automatic test_sparse;
    logic [N-1:0] v;
    logic [7:0] e;
    int first_c, last_c, done_c, ndone;
    v = '0; v[0] = 1'b1; v[5] = 1'b1; v[85] = 1'b1;
    grant_ready = 1'b1;
    drive_req(v, N);
    first_c = -1; last_c = -1; done_c = -1; ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (grant_valid) begin
        if (first_c < 0) first_c = c;
        last_c = c;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sparse_extra: unexpected grant idx=%0d", grant_idx);
        end else begin
          e = exp_q.pop_front();
          if ({grant_last, grant_idx} !== e) begin
            errors++;
            $display("FAIL sparse_grant: last=%b idx=%0d, need last=%b idx=%0d",
                     grant_last, grant_idx, e[7], e[6:0]);
          end
        end
      end
      if (done) begin
        ndone++;
        done_c = c;
        checks++;
        if (grant_count !== 7'd3) begin
          errors++;
          $display("FAIL sparse_count: grant_count=%0d, need 3", grant_count);
        end
      end
    end
    checks++;
    if (last_c - first_c != 2 || first_c != 0) begin
      errors++;
      $display("FAIL sparse_rate: grants on cycles %0d..%0d, need 0..2", first_c, last_c);
    end
    checks++;
    if (ndone != 1 || done_c != last_c + 1) begin
      errors++;
      $display("FAIL sparse_done: pulses=%0d at %0d, need 1 at %0d", ndone, done_c, last_c + 1);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sparse_left: %0d grants missing, need 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_backpressure;
    logic [N-1:0] v;
    logic [7:0] e;
    logic seen_done;
    v = '0; v[2] = 1'b1; v[3] = 1'b1;
    grant_ready = 1'b0;
    drive_req(v, N);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (grant_valid !== 1'b1 || grant_idx !== 7'd3 || grant_last !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold: gv=%b idx=%0d last=%b, need 1 3 0", grant_valid, grant_idx, grant_last);
      end
    end
    grant_ready = 1'b1;
    seen_done = 1'b0;
    for (int c = 0; c < 10 && !seen_done; c++) begin
      if (c > 0) @(negedge clk);
      if (grant_valid) begin
        checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hff;
        if ({grant_last, grant_idx} !== e) begin
          errors++;
          $display("FAIL bp_grant: last=%b idx=%0d, need last=%b idx=%0d",
                   grant_last, grant_idx, e[7], e[6:0]);
        end
      end
      if (done) begin
        seen_done = 1'b1;
        checks++;
        if (grant_count !== 7'd2) begin
          errors++;
          $display("FAIL bp_count: grant_count=%0d, need 2", grant_count);
        end
      end
    end
    checks++;
    if (!seen_done || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_finish: done=%b left=%0d, need done and 0 left", seen_done, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_empty;
    grant_ready = 1'b1;
    drive_req('0, N);
    @(negedge clk);
    checks++;
    if (grant_valid !== 1'b0 || done !== 1'b1 || grant_count !== 7'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL empty_done: gv=%b done=%b cnt=%0d busy=%b, need 0 1 0 1",
               grant_valid, done, grant_count, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL empty_after: done=%b ready=%b, need 0 1", done, req_ready);
    end
  endtask

  task automatic test_abort;
    logic [7:0] e;
    int dcount;
    grant_ready = 1'b1;
    drive_req('1, 9);
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      checks++;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hff;
      if (grant_valid !== 1'b1 || {grant_last, grant_idx} !== e) begin
        errors++;
        $display("FAIL abort_grant: gv=%b last=%b idx=%0d, need 1 last=%b idx=%0d",
                 grant_valid, grant_last, grant_idx, e[7], e[6:0]);
      end
    end
    @(negedge clk);
    checks++;
    if (grant_valid !== 1'b1 || grant_idx !== 7'd10) begin
      errors++;
      $display("FAIL abort_tenth: gv=%b idx=%0d, need 1 10", grant_valid, grant_idx);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    checks++;
    if (grant_valid !== 1'b0 || grant_idx !== 7'd127 || grant_count !== 7'd9 ||
        busy !== 1'b0 || req_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_after: gv=%b idx=%0d cnt=%0d busy=%b ready=%b done=%b, need 0 127 9 0 1 0",
               grant_valid, grant_idx, grant_count, busy, req_ready, done);
    end
    dcount = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done || grant_valid) dcount++;
    end
    checks++;
    if (dcount != 0) begin
      errors++;
      $display("FAIL abort_quiet: %0d cycles with done/grant, need 0", dcount);
    end
  endtask

  task automatic test_abort_idle;
    @(negedge clk);
    abort     = 1'b1;
    req_valid = 1'b1;
    req_vec   = '1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle_ready: req_ready=%b, need 0", req_ready);
    end
    @(negedge clk);
    abort     = 1'b0;
    req_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || grant_valid !== 1'b0 || grant_count !== 7'd9) begin
      errors++;
      $display("FAIL abort_idle_state: busy=%b gv=%b cnt=%0d, need 0 0 9", busy, grant_valid, grant_count);
    end
  endtask

  task automatic test_reset_mid;
    logic [N-1:0] v;
    logic [7:0] e;
    grant_ready = 1'b1;
    drive_req('1, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (grant_valid !== 1'b0 || grant_idx !== 7'd127 || grant_count !== 7'd0 || busy !== 1'b0 ||
        done !== 1'b0 || req_ready !== 1'b1 || grant_last !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: gv=%b idx=%0d cnt=%0d busy=%b done=%b ready=%b last=%b, need 0 127 0 0 0 1 0",
               grant_valid, grant_idx, grant_count, busy, done, req_ready, grant_last);
    end
    v = '0; v[40] = 1'b1;
    drive_req(v, N);
    @(negedge clk);
    checks++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hff;
    if (grant_valid !== 1'b1 || {grant_last, grant_idx} !== e) begin
      errors++;
      $display("FAIL rst_new_grant: gv=%b last=%b idx=%0d, need 1 last=%b idx=%0d",
               grant_valid, grant_last, grant_idx, e[7], e[6:0]);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || grant_count !== 7'd1) begin
      errors++;
      $display("FAIL rst_new_done: done=%b cnt=%0d, need 1 1", done, grant_count);
    end
  endtask

  task automatic test_random;
    logic [N-1:0] v;
    logic [7:0] e;
    int expn;
    logic seen_done;
    for (int b = 0; b < 4; b++) begin
      v = '0;
      for (int k = 0; k < N; k++) v[k] = ($urandom_range(0, 3) == 0);
      expn = $countones(v);
      drive_req(v, N);
      seen_done = 1'b0;
      for (int c = 0; c < 600 && !seen_done; c++) begin
        @(negedge clk);
        if (done) begin
          seen_done = 1'b1;
          checks++;
          if (grant_count !== 7'(expn) || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rand_done: batch %0d cnt=%0d left=%0d, need cnt=%0d left=0",
                     b, grant_count, exp_q.size(), expn);
            exp_q.delete();
          end
        end else begin
          grant_ready = ($urandom_range(0, 1) == 1);
          if (grant_valid && grant_ready) begin
            checks++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hff;
            if ({grant_last, grant_idx} !== e) begin
              errors++;
              $display("FAIL rand_grant: batch %0d last=%b idx=%0d, need last=%b idx=%0d",
                       b, grant_last, grant_idx, e[7], e[6:0]);
            end
          end
        end
      end
      if (!seen_done) begin
        checks++;
        errors++;
        $display("FAIL rand_timeout: batch %0d no done within 600 cycles", b);
        exp_q.delete();
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_vec = '0;
    abort = 1'b0;
    grant_ready = 1'b0;
    test_reset;
    test_sparse;
    test_backpressure;
    test_empty;
    test_abort;
    test_abort_idle;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
